io_timer: RTL

IO_TIMER -- requirements
Module: io_timer

---
 rtl/io_timer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/io_timer.sv
`default_nettype none
// ============================================================================
// Module      : io_timer
// Description : Two independent 16-bit down-counting timer/counter channels
//               with bus-mapped mode/init/status/count registers.
// Revision    : 1.0 - initial release
// ============================================================================
module io_timer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        isR,
    input  logic        isW,
    input  logic [3:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic [1:0]  pulse_in,
    output logic [1:0]  tout
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic        w_bus_sel;
    logic        w_wr;
    logic        w_rd;
    logic [15:0] w_count [2];
    logic [1:0]  w_run;
    logic [1:0]  w_done;
    logic        w_unused_addr0;

    // A simultaneous read and write is treated as a write only.
    assign w_bus_sel      = cs && !addr[3];
    assign w_wr           = w_bus_sel && isW;
    assign w_rd           = w_bus_sel && isR && !isW;
    assign w_unused_addr0 = addr[0];

    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            logic [1:0]             r_mode;
            logic [15:0]            r_init;
            logic [15:0]            r_count;
            logic [0:0]             r_state;
            logic                   r_done;
            logic                   r_tout;
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_edge;
            logic                   w_sel_ch;
            logic                   w_init_wr;
            logic                   w_mode_wr;
            logic                   w_stat_rd;
            logic                   w_tick;

            assign w_sel_ch  = (addr[1] == 1'(g));
            assign w_init_wr = w_wr && addr[2] && w_sel_ch;
            assign w_mode_wr = w_wr && !addr[2] && w_sel_ch;
            assign w_stat_rd = w_rd && !addr[2] && w_sel_ch;
            assign w_tick    = r_mode[0] ? (r_sync[SYNC_STAGES-1] && !r_edge) : 1'b1;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mode  <= '0;
                    r_init  <= '0;
                    r_count <= '0;
                    r_state <= c_st_idle;
                    r_done  <= 1'b0;
                    r_tout  <= 1'b0;
                    r_sync  <= '0;
                    r_edge  <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in[g]};
                    r_edge <= r_sync[SYNC_STAGES-1];
                    r_tout <= 1'b0;
                    // Clear first so a coincident terminal count below wins.
                    if (w_stat_rd) begin
                        r_done <= 1'b0;
                    end
                    if (w_init_wr) begin
                        r_init  <= wdata;
                        r_count <= wdata;
                        r_state <= (wdata != 16'd0) ? c_st_run : c_st_idle;
                    end else if (w_mode_wr) begin
                        r_mode  <= wdata[1:0];
                        r_state <= c_st_idle;
                    end else if (r_state == c_st_run && w_tick) begin
                        if (r_count == 16'd1) begin
                            r_done <= 1'b1;
                            r_tout <= 1'b1;
                            if (r_mode[1]) begin
                                r_count <= r_init;
                            end else begin
                                r_count <= 16'd0;
                                r_state <= c_st_idle;
                            end
                        end else if (r_count != 16'd0) begin
                            r_count <= r_count - 16'd1;
                        end
                    end
                end
            end

            assign w_count[g] = r_count;
            assign w_run[g]   = (r_state == c_st_run);
            assign w_done[g]  = r_done;
            assign tout[g]    = r_tout;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if (cs && isR && !addr[3]) begin
            case (addr[2:1])
                2'b00:   rdata = {w_run[0], 14'b0, w_done[0]};
                2'b01:   rdata = {w_run[1], 14'b0, w_done[1]};
                2'b10:   rdata = w_count[0];
                default: rdata = w_count[1];
            endcase
        end
    end

endmodule
`default_nettype wire
